// File: rtl/dcache_2way_if.sv
// CPU (MEM stage) and line-memory signals of the 2-way data cache, bundled for port connection.
// slave: cache side; master: the pipeline/memory side that drives requests and acknowledges.
interface dcache_2way_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int CNT_W  = 32
);
  logic [ADDR_W-1:0] p1_addr_i;
  logic [31:0]       p1_data_i;
  logic              p1_MemRead_i;
  logic              p1_MemWrite_i;
  logic [31:0]       p1_data_o;
  logic              p1_stall_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o;
  logic              mem_write_o;
  logic [CNT_W-1:0]  acc_cnt_o;
  logic [CNT_W-1:0]  miss_cnt_o;

  modport slave (
    input  p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
           acc_cnt_o, miss_cnt_o
  );

  modport master (
    output p1_addr_i, p1_data_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o,
           acc_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back, write-allocate L1 data cache with per-set LRU,
// line-wide memory handshake and saturating access/miss counters.
module dcache_2way_top #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32,
  parameter int CNT_W  = 32
) (
  input logic          clk_i,
  input logic          rst_i,
  dcache_2way_if.slave bus
);
  localparam int OFF  = $clog2(LINE_W / 8);
  localparam int IDX  = $clog2(SETS);
  localparam int TAG  = ADDR_W - IDX - OFF;
  localparam int WSEL = OFF - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, WB_GAP, REFILL} state_t;
  state_t state_q, state_d;

  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   dirty_q [2];
  logic [SETS-1:0]   lru_q;
  logic [TAG-1:0]    tag_q  [2][SETS];
  logic [LINE_W-1:0] line_q [2][SETS];

  logic [TAG-1:0]    miss_tag_q;
  logic [IDX-1:0]    miss_idx_q;
  logic              victim_q;
  logic              mem_en_q, mem_en_d, mem_wr_q, mem_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [LINE_W-1:0] mem_data_q, mem_data_d;
  logic [CNT_W-1:0]  acc_q, miss_q;

  logic              req, hit0, hit1, hit, hit_way, done, miss_start, fill, victim_sel;
  logic [TAG-1:0]    a_tag;
  logic [IDX-1:0]    a_idx;
  logic [WSEL-1:0]   a_word;
  logic [LINE_W-1:0] hit_line;
  logic              unused_addr_bits;

  assign req    = bus.p1_MemRead_i | bus.p1_MemWrite_i;
  assign a_tag  = bus.p1_addr_i[ADDR_W-1:IDX+OFF];
  assign a_idx  = bus.p1_addr_i[IDX+OFF-1:OFF];
  assign a_word = bus.p1_addr_i[OFF-1:2];
  assign unused_addr_bits = ^bus.p1_addr_i[1:0];

  assign hit0     = valid_q[0][a_idx] && (tag_q[0][a_idx] == a_tag);
  assign hit1     = valid_q[1][a_idx] && (tag_q[1][a_idx] == a_tag);
  assign hit      = hit0 | hit1;
  assign hit_way  = hit1;
  assign hit_line = line_q[hit_way][a_idx];

  assign done       = req && (state_q == IDLE) && hit;
  assign miss_start = req && (state_q == IDLE) && !hit;
  assign fill       = (state_q == REFILL) && bus.mem_ack_i;
  // Prefer an empty way; only fall back to LRU when the set is full.
  assign victim_sel = !valid_q[0][a_idx] ? 1'b0 :
                      !valid_q[1][a_idx] ? 1'b1 : lru_q[a_idx];

  assign bus.p1_stall_o   = req & ~done;
  assign bus.p1_data_o    = done ? hit_line[{a_word, 5'b0} +: 32] : 32'h0;
  assign bus.mem_enable_o = mem_en_q;
  assign bus.mem_write_o  = mem_wr_q;
  assign bus.mem_addr_o   = mem_addr_q;
  assign bus.mem_data_o   = mem_data_q;
  assign bus.acc_cnt_o    = acc_q;
  assign bus.miss_cnt_o   = miss_q;

  always_comb begin
    state_d    = state_q;
    mem_en_d   = mem_en_q;
    mem_wr_d   = mem_wr_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    case (state_q)
      IDLE: if (miss_start) begin
        mem_en_d = 1'b1;
        if (valid_q[victim_sel][a_idx] && dirty_q[victim_sel][a_idx]) begin
          state_d    = WRITEBACK;
          mem_wr_d   = 1'b1;
          mem_addr_d = {tag_q[victim_sel][a_idx], a_idx, {OFF{1'b0}}};
          mem_data_d = line_q[victim_sel][a_idx];
        end else begin
          state_d    = REFILL;
          mem_wr_d   = 1'b0;
          mem_addr_d = {a_tag, a_idx, {OFF{1'b0}}};
        end
      end
      WRITEBACK: if (bus.mem_ack_i) begin
        state_d  = WB_GAP;
        mem_en_d = 1'b0;
        mem_wr_d = 1'b0;
      end
      WB_GAP: begin
        state_d    = REFILL;
        mem_en_d   = 1'b1;
        mem_addr_d = {miss_tag_q, miss_idx_q, {OFF{1'b0}}};
      end
      REFILL: if (bus.mem_ack_i) begin
        state_d  = IDLE;
        mem_en_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      valid_q[0] <= '0;
      valid_q[1] <= '0;
      dirty_q[0] <= '0;
      dirty_q[1] <= '0;
      lru_q      <= '0;
      acc_q      <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_wr_q   <= mem_wr_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      if (done) begin
        lru_q[a_idx] <= ~hit_way;
        if (bus.p1_MemWrite_i) dirty_q[hit_way][a_idx] <= 1'b1;
      end
      if (fill) begin
        valid_q[victim_q][miss_idx_q] <= 1'b1;
        dirty_q[victim_q][miss_idx_q] <= 1'b0;
        lru_q[miss_idx_q]             <= ~victim_q;
      end
      if (done && (acc_q != {CNT_W{1'b1}}))        acc_q  <= acc_q + 1'b1;
      if (miss_start && (miss_q != {CNT_W{1'b1}})) miss_q <= miss_q + 1'b1;
    end
  end

  // Line/tag storage and the miss latch carry data only and are left unreset.
  always_ff @(posedge clk_i) begin
    if (miss_start) begin
      miss_tag_q <= a_tag;
      miss_idx_q <= a_idx;
      victim_q   <= victim_sel;
    end
    if (done && bus.p1_MemWrite_i) line_q[hit_way][a_idx][{a_word, 5'b0} +: 32] <= bus.p1_data_i;
    if (fill) begin
      line_q[victim_q][miss_idx_q] <= bus.mem_data_i;
      tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
    end
  end
endmodule

// File: tb/tb_dcache_2way_top.sv
// Scoreboard bench for dcache_2way_top: stimulus queues expected reads and memory requests,
// a monitor pops and compares them; a backing-memory responder acks line requests.
module tb_dcache_2way_top;
  localparam int ADDR_W = 32, LINE_W = 256, SETS = 32, CNT_W = 4;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  dcache_2way_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .CNT_W(CNT_W)) bus ();
  dcache_2way_top #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .SETS(SETS), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus)
  );

  typedef struct { string name; logic [31:0] data; } cpu_exp_t;
  typedef struct { string name; logic wr; logic [31:0] addr; logic [255:0] data; } mem_exp_t;
  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int tests = 0;
  int fails = 0;
  logic [255:0] backing [logic [31:0]];
  bit ack_hold = 1'b0;
  int ack_lat  = 3;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[32*w +: 32] = base + 32'(w);
    return l;
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] key);
    if (backing.exists(key)) return backing[key];
    return pat({key[15:0], 16'h0});
  endfunction

  task automatic push_mem(input string name, input bit wr, input logic [31:0] addr, input logic [255:0] data);
    mem_exp_t e;
    e.name = name; e.wr = wr; e.addr = addr; e.data = data;
    mem_q.push_back(e);
  endtask

  // Memory responder: acks ack_lat cycles after a request appears.
  initial begin
    int wait_cnt;
    logic [31:0] key;
    wait_cnt = 0;
    bus.mem_ack_i  = 1'b0;
    bus.mem_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      bus.mem_ack_i = 1'b0;
      if (!bus.mem_enable_o || !rst_i) wait_cnt = 0;
      else if (!ack_hold) begin
        wait_cnt++;
        if (wait_cnt >= ack_lat) begin
          wait_cnt = 0;
          key = bus.mem_addr_o;
          if (bus.mem_write_o) backing[key] = bus.mem_data_o;
          else bus.mem_data_i = line_of(key);
          bus.mem_ack_i = 1'b1;
        end
      end
    end
  end

  // Monitor: completed reads and new memory requests are popped from the scoreboard.
  initial begin
    logic en_prev;
    cpu_exp_t ce;
    mem_exp_t me;
    en_prev = 1'b0;
    forever begin
      @(negedge clk_i);
      if (rst_i && bus.p1_MemRead_i && !bus.p1_MemWrite_i && !bus.p1_stall_o) begin
        if (cpu_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_read: data %0h with no expected read queued", bus.p1_data_o);
        end else begin
          ce = cpu_q.pop_front();
          check(ce.name, bus.p1_data_o, ce.data);
        end
      end
      if (bus.mem_enable_o && !en_prev) begin
        if (mem_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_mem_req: addr %0h write %0b with none expected", bus.mem_addr_o, bus.mem_write_o);
        end else begin
          me = mem_q.pop_front();
          check({me.name, "_addr"}, bus.mem_addr_o, me.addr);
          check({me.name, "_write"}, bus.mem_write_o, me.wr);
          if (me.wr) check({me.name, "_data"}, bus.mem_data_o, me.data);
        end
      end
      en_prev = bus.mem_enable_o;
    end
  end

  task automatic cpu_access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                            input logic [31:0] exp, input string name, output int stalls);
    cpu_exp_t e;
    if (!wr) begin
      e.name = name; e.data = exp;
      cpu_q.push_back(e);
    end
    bus.p1_addr_i = addr; bus.p1_data_i = wdata;
    bus.p1_MemRead_i = !wr; bus.p1_MemWrite_i = wr;
    stalls = 0;
    forever begin
      @(negedge clk_i);
      if (!bus.p1_stall_o) break;
      stalls++;
      if (stalls > 200) begin
        tests++; fails++;
        $display("FAIL %s_timeout: stalled %0d cycles, expected completion", name, stalls);
        break;
      end
    end
    @(posedge clk_i); #2;
    bus.p1_MemRead_i = 1'b0; bus.p1_MemWrite_i = 1'b0;
  endtask

  task automatic wait_en(input bit lvl, input string name);
    int n;
    n = 0;
    while (bus.mem_enable_o !== lvl) begin
      @(posedge clk_i); #2;
      n++;
      if (n > 100) begin
        tests++; fails++;
        $display("FAIL %s_timeout: mem_enable_o %0b, expected %0b", name, bus.mem_enable_o, lvl);
        break;
      end
    end
  endtask

  task automatic measure_gap(output int gap);
    wait_en(1'b1, "gap_wb");
    wait_en(1'b0, "gap_ack");
    gap = 0;
    while (!bus.mem_enable_o && gap < 50) begin
      @(posedge clk_i); #2;
      gap++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_enable"}, bus.mem_enable_o, 1'b0);
    check({tag, "_write"},  bus.mem_write_o, 1'b0);
    check({tag, "_addr"},   bus.mem_addr_o, 32'h0);
    check({tag, "_data"},   bus.mem_data_o, 256'h0);
    check({tag, "_acc"},    bus.acc_cnt_o, 4'd0);
    check({tag, "_miss"},   bus.miss_cnt_o, 4'd0);
    check({tag, "_stall"},  bus.p1_stall_o, 1'b0);
    check({tag, "_rdata"},  bus.p1_data_o, 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b1;
    check_reset_state(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int s, gap, s3;
    logic [255:0] l40, exp_wb3, exp_wb5;
    bus.p1_addr_i = '0; bus.p1_data_i = '0;
    bus.p1_MemRead_i = 1'b0; bus.p1_MemWrite_i = 1'b0;
    l40 = pat(32'h0040_0000);
    l40[95:64] = 32'hDEAD_BEEF;
    backing[32'h40] = l40;
    exp_wb3 = l40;
    exp_wb3[63:32] = 32'h1234_5678;
    exp_wb5 = pat(32'h1000_0000);
    exp_wb5[95:64] = 32'hCAFE_F00D;

    do_reset("rst0");

    // Clean miss on 0x40, then the retried address moves to 0x48.
    push_mem("t1_refill", 1'b0, 32'h40, '0);
    bus.p1_addr_i = 32'h40; bus.p1_MemRead_i = 1'b1;
    @(negedge clk_i);
    check("t1_stall", bus.p1_stall_o, 1'b1);
    wait_en(1'b1, "t1_req");
    wait_en(1'b0, "t1_done");
    cpu_access(32'h48, 1'b0, 0, 32'hDEAD_BEEF, "t1_rd48a", s);
    check("t1_rd48a_stalls", s, 0);
    cpu_access(32'h48, 1'b0, 0, 32'hDEAD_BEEF, "t1_rd48b", s);
    check("t1_rd48b_stalls", s, 0);
    check("t1_miss_cnt", bus.miss_cnt_o, 4'd1);
    check("t1_acc_cnt", bus.acc_cnt_o, 4'd2);

    // Fill set 2, touch 0x40, conflict on 0x840 evicts 0x440's way.
    push_mem("t2_refill440", 1'b0, 32'h440, '0);
    cpu_access(32'h440, 1'b0, 0, 32'h0440_0000, "t2_rd440", s);
    check("t2_rd440_missed", s != 0, 1'b1);
    cpu_access(32'h40, 1'b0, 0, 32'h0040_0000, "t2_rd40", s);
    check("t2_rd40_stalls", s, 0);
    push_mem("t2_refill840", 1'b0, 32'h840, '0);
    cpu_access(32'h840, 1'b0, 0, 32'h0840_0000, "t2_rd840", s);
    cpu_access(32'h40, 1'b0, 0, 32'h0040_0000, "t2_rd40_again", s);
    check("t2_rd40_again_stalls", s, 0);
    push_mem("t2_refill440b", 1'b0, 32'h440, '0);
    cpu_access(32'h44C, 1'b0, 0, 32'h0440_0003, "t2_rd44c", s);
    check("t2_rd44c_missed", s != 0, 1'b1);

    // Write-allocate, then dirty eviction through WRITEBACK / WB_GAP / REFILL.
    do_reset("rst1");
    push_mem("t3_refill40", 1'b0, 32'h40, '0);
    cpu_access(32'h44, 1'b1, 32'h1234_5678, 0, "t3_wr44", s);
    push_mem("t3_refill440", 1'b0, 32'h440, '0);
    cpu_access(32'h440, 1'b0, 0, 32'h0440_0000, "t3_rd440", s);
    push_mem("t3_wb40", 1'b1, 32'h40, exp_wb3);
    push_mem("t3_refill840", 1'b0, 32'h840, '0);
    fork
      cpu_access(32'h840, 1'b0, 0, 32'h0840_0000, "t3_rd840", s3);
      measure_gap(gap);
    join
    check("t3_gap_cycles", gap, 1);
    push_mem("t3_refill40b", 1'b0, 32'h40, '0);
    cpu_access(32'h44, 1'b0, 0, 32'h1234_5678, "t3_rd44", s);
    cpu_access(32'h48, 1'b0, 0, 32'hDEAD_BEEF, "t3_rd48", s);
    check("t3_rd48_stalls", s, 0);

    // Request dropped during REFILL still installs the line.
    push_mem("t4_refill1000", 1'b0, 32'h1000, '0);
    bus.p1_addr_i = 32'h1000; bus.p1_MemRead_i = 1'b1;
    wait_en(1'b1, "t4_req");
    bus.p1_MemRead_i = 1'b0;
    wait_en(1'b0, "t4_done");
    @(posedge clk_i); #2;
    cpu_access(32'h1004, 1'b0, 0, 32'h1000_0001, "t4_rd1004", s);
    check("t4_rd1004_stalls", s, 0);

    // Reset asserted while a write-back is outstanding.
    cpu_access(32'h1008, 1'b1, 32'hCAFE_F00D, 0, "t5_wr1008", s);
    check("t5_wr1008_stalls", s, 0);
    push_mem("t5_refill1400", 1'b0, 32'h1400, '0);
    cpu_access(32'h1400, 1'b0, 0, 32'h1400_0000, "t5_rd1400", s);
    push_mem("t5_wb1000", 1'b1, 32'h1000, exp_wb5);
    ack_hold = 1'b1;
    bus.p1_addr_i = 32'h1800; bus.p1_MemRead_i = 1'b1;
    wait_en(1'b1, "t5_wb");
    check("t5_wb_write", bus.mem_write_o, 1'b1);
    @(posedge clk_i); #3;
    rst_i = 1'b0;
    #1;
    check("t5_async_enable", bus.mem_enable_o, 1'b0);
    check("t5_async_write", bus.mem_write_o, 1'b0);
    check("t5_async_acc", bus.acc_cnt_o, 4'd0);
    check("t5_async_miss", bus.miss_cnt_o, 4'd0);
    bus.p1_MemRead_i = 1'b0;
    ack_hold = 1'b0;
    @(posedge clk_i); #2;
    rst_i = 1'b1;
    push_mem("t5_refill1000", 1'b0, 32'h1000, '0);
    cpu_access(32'h1008, 1'b0, 0, 32'h1000_0002, "t5_rd1008", s);
    check("t5_rd1008_missed", s != 0, 1'b1);
    check("t5_miss_cnt", bus.miss_cnt_o, 4'd1);
    check("t5_acc_cnt", bus.acc_cnt_o, 4'd1);

    // Access counter saturates at 15.
    for (int i = 0; i < 20; i++) cpu_access(32'h1008, 1'b0, 0, 32'h1000_0002, "t6_hit", s);
    check("t6_acc_sat", bus.acc_cnt_o, 4'd15);
    check("t6_miss_cnt", bus.miss_cnt_o, 4'd1);

    repeat (2) @(posedge clk_i);
    check("cpu_q_drained", cpu_q.size(), 0);
    check("mem_q_drained", mem_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
